// File: rtl/hazard_sched_if.sv
// -----------------------------------------------------------------------------
// hazard_sched_if
// Bundles the pipeline-side signals of the hazard scheduler.
//   Hazard inputs : rs1D, rs2D, use_rs1D, use_rs2D, rdE, mem_readE,
//                   redirectE, mem_reqM
//   Controls      : stallF, stallD, flushD, bubbleE, holdE, holdM, mem_ack
//   Debug / perf  : stall_cycles (CNT_W bits), state (2 bits)
// Modports: master = pipeline side (drives hazards, receives controls),
//           slave  = scheduler side.
// -----------------------------------------------------------------------------
interface hazard_sched_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic             use_rs1D;
    logic             use_rs2D;
    logic [4:0]       rdE;
    logic             mem_readE;
    logic             redirectE;
    logic             mem_reqM;
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             bubbleE;
    logic             holdE;
    logic             holdM;
    logic             mem_ack;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    modport master (
        output rs1D, rs2D, use_rs1D, use_rs2D, rdE, mem_readE, redirectE, mem_reqM,
        input  stallF, stallD, flushD, bubbleE, holdE, holdM, mem_ack, stall_cycles, state
    );

    modport slave (
        input  rs1D, rs2D, use_rs1D, use_rs2D, rdE, mem_readE, redirectE, mem_reqM,
        output stallF, stallD, flushD, bubbleE, holdE, holdM, mem_ack, stall_cycles, state
    );
endinterface

// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
// Hazard scheduler for the 5-stage RV32I pipeline: produces hold/bubble/flush
// controls for load-use interlocks, E-stage redirects and multi-cycle data
// memory accesses in M, plus a saturating stall-cycle counter.
// Ports:
//   CLK   - clock, rising edge
//   NRST  - asynchronous active-low reset; forces all controls to 0
//   bus   - hazard_sched_if.slave: hazard inputs, controls, counter, state
// Parameters:
//   MEM_LAT - data memory latency in cycles (1..15)
//   CNT_W   - stall counter width
// -----------------------------------------------------------------------------
module hazard_sched #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic           CLK,
    input  logic           NRST,
    hazard_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_MWAIT = 2'd2
    } state_t;

    localparam bit         MULTI_CYCLE = (MEM_LAT > 1);
    // Cycles still frozen after the first freeze cycle spent outside MWAIT.
    localparam logic [3:0] CNT_START   = MULTI_CYCLE ? 4'(MEM_LAT - 2) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic lu_s;
    logic freeze_s;
    logic apply_s;
    logic lu_en_s;
    logic stallF_s, stallD_s, flushD_s, bubbleE_s, holdE_s, holdM_s, ack_s;

    // Load-use detection against the load currently in E.
    always_comb begin
        lu_s = bus.mem_readE & (bus.rdE != 5'd0) &
               ((bus.use_rs1D & (bus.rs1D == bus.rdE)) |
                (bus.use_rs2D & (bus.rs2D == bus.rdE)));
    end

    // Next-state and control decode; memory freeze outranks redirect outranks load-use.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        freeze_s  = 1'b0;
        apply_s   = 1'b0;
        lu_en_s   = 1'b0;
        ack_s     = 1'b0;
        stallF_s  = 1'b0;
        stallD_s  = 1'b0;
        flushD_s  = 1'b0;
        bubbleE_s = 1'b0;
        holdE_s   = 1'b0;
        holdM_s   = 1'b0;

        case (state_q)
            ST_MWAIT: begin
                if (cnt_q != 4'd0) begin
                    freeze_s = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                    state_d  = ST_MWAIT;
                end else begin
                    // Final access cycle: ack and resolve whatever was held back.
                    ack_s   = 1'b1;
                    apply_s = 1'b1;
                    lu_en_s = 1'b1;
                end
            end
            default: begin
                // RUN, LDUSE and the unused encoding all behave as RUN here.
                if (bus.mem_reqM && MULTI_CYCLE) begin
                    freeze_s = 1'b1;
                    cnt_d    = CNT_START;
                    state_d  = ST_MWAIT;
                end else begin
                    ack_s   = bus.mem_reqM;
                    apply_s = 1'b1;
                    // The load that caused LDUSE now sits in M and is forwarded.
                    lu_en_s = (state_q != ST_LDUSE);
                end
            end
        endcase

        if (freeze_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            holdE_s  = 1'b1;
            holdM_s  = 1'b1;
        end else if (apply_s) begin
            if (bus.redirectE) begin
                // D instruction is killed, so any load-use on it is moot.
                flushD_s  = 1'b1;
                bubbleE_s = 1'b1;
                state_d   = ST_RUN;
            end else if (lu_s && lu_en_s) begin
                stallF_s  = 1'b1;
                stallD_s  = 1'b1;
                bubbleE_s = 1'b1;
                state_d   = ST_LDUSE;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, wait counter and saturating stall counter.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.stallF && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end else begin
                stall_q <= stall_q;
            end
        end
    end

    // Controls are gated by NRST so they drop the moment reset asserts.
    assign bus.stallF       = stallF_s  & NRST;
    assign bus.stallD       = stallD_s  & NRST;
    assign bus.flushD       = flushD_s  & NRST;
    assign bus.bubbleE      = bubbleE_s & NRST;
    assign bus.holdE        = holdE_s   & NRST;
    assign bus.holdM        = holdM_s   & NRST;
    assign bus.mem_ack      = ack_s     & NRST;
    assign bus.stall_cycles = stall_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_hazard_sched
// Drives three scheduler instances (MEM_LAT=2/CNT_W=16, MEM_LAT=4/CNT_W=4,
// MEM_LAT=1/CNT_W=16) with shared directed stimulus. A behavioural model
// tracks "cycles until the memory ack" and "a load-use bubble was just taken"
// per instance and is compared against every instance on each falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_sched;

    logic       CLK = 1'b0;
    logic       NRST = 1'b0;
    logic [4:0] rs1D, rs2D, rdE;
    logic       use_rs1D, use_rs2D, mem_readE, redirectE, mem_reqM;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    hazard_sched_if #(.CNT_W(16)) if_a ();
    hazard_sched_if #(.CNT_W(4))  if_b ();
    hazard_sched_if #(.CNT_W(16)) if_c ();

    assign if_a.rs1D = rs1D;      assign if_b.rs1D = rs1D;      assign if_c.rs1D = rs1D;
    assign if_a.rs2D = rs2D;      assign if_b.rs2D = rs2D;      assign if_c.rs2D = rs2D;
    assign if_a.use_rs1D = use_rs1D;  assign if_b.use_rs1D = use_rs1D;  assign if_c.use_rs1D = use_rs1D;
    assign if_a.use_rs2D = use_rs2D;  assign if_b.use_rs2D = use_rs2D;  assign if_c.use_rs2D = use_rs2D;
    assign if_a.rdE = rdE;        assign if_b.rdE = rdE;        assign if_c.rdE = rdE;
    assign if_a.mem_readE = mem_readE;  assign if_b.mem_readE = mem_readE;  assign if_c.mem_readE = mem_readE;
    assign if_a.redirectE = redirectE;  assign if_b.redirectE = redirectE;  assign if_c.redirectE = redirectE;
    assign if_a.mem_reqM = mem_reqM;    assign if_b.mem_reqM = mem_reqM;    assign if_c.mem_reqM = mem_reqM;

    hazard_sched #(.MEM_LAT(2), .CNT_W(16)) dut_a (.CLK(CLK), .NRST(NRST), .bus(if_a.slave));
    hazard_sched #(.MEM_LAT(4), .CNT_W(4))  dut_b (.CLK(CLK), .NRST(NRST), .bus(if_b.slave));
    hazard_sched #(.MEM_LAT(1), .CNT_W(16)) dut_c (.CLK(CLK), .NRST(NRST), .bus(if_c.slave));

    // Control vector order: {stallF, stallD, flushD, bubbleE, holdE, holdM, mem_ack}
    logic [6:0]  outs [3];
    logic [1:0]  sts  [3];
    logic [15:0] scs  [3];

    assign outs[0] = {if_a.stallF, if_a.stallD, if_a.flushD, if_a.bubbleE, if_a.holdE, if_a.holdM, if_a.mem_ack};
    assign outs[1] = {if_b.stallF, if_b.stallD, if_b.flushD, if_b.bubbleE, if_b.holdE, if_b.holdM, if_b.mem_ack};
    assign outs[2] = {if_c.stallF, if_c.stallD, if_c.flushD, if_c.bubbleE, if_c.holdE, if_c.holdM, if_c.mem_ack};
    assign sts[0] = if_a.state;
    assign sts[1] = if_b.state;
    assign sts[2] = if_c.state;
    assign scs[0] = if_a.stall_cycles;
    assign scs[1] = {12'd0, if_b.stall_cycles};
    assign scs[2] = if_c.stall_cycles;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lat  [3] = '{2, 4, 1};
    int cmax [3] = '{65535, 15, 65535};
    int pend [3] = '{0, 0, 0};   // cycles until the pending access acks (0 = none)
    bit shadow [3] = '{1'b0, 1'b0, 1'b0}; // a load-use bubble was taken last cycle
    int scnt [3] = '{0, 0, 0};

    always @(negedge CLK) begin : model_cmp
        logic [6:0] e;
        logic [1:0] es;
        bit luv, fr, ack, red, lus, rules;
        for (int i = 0; i < 3; i++) begin
            if (!NRST) begin
                pend[i] = 0; shadow[i] = 1'b0; scnt[i] = 0;
                chk($sformatf("rst_ctl%0d", i), 32'(outs[i]), 32'd0);
                chk($sformatf("rst_state%0d", i), 32'(sts[i]), 32'd0);
                chk($sformatf("rst_cnt%0d", i), 32'(scs[i]), 32'd0);
            end else begin
                es  = (pend[i] > 0) ? 2'd2 : (shadow[i] ? 2'd1 : 2'd0);
                luv = mem_readE && (rdE != 5'd0) &&
                      ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
                fr = 1'b0; ack = 1'b0; red = 1'b0; lus = 1'b0; rules = 1'b0;
                if (pend[i] > 1) begin
                    fr = 1'b1; pend[i] = pend[i] - 1;
                end else if (pend[i] == 1) begin
                    ack = 1'b1; pend[i] = 0; rules = 1'b1;
                end else if (mem_reqM && lat[i] > 1) begin
                    fr = 1'b1; pend[i] = lat[i] - 1;
                end else begin
                    ack = mem_reqM; rules = 1'b1;
                end
                if (rules) begin
                    if (redirectE) red = 1'b1;
                    else if (luv && !shadow[i]) lus = 1'b1;
                end
                shadow[i] = lus;
                e = {fr | lus, fr | lus, red, red | lus, fr, fr, ack};
                chk($sformatf("ctl%0d", i), 32'(outs[i]), 32'(e));
                chk($sformatf("state%0d", i), 32'(sts[i]), 32'(es));
                chk($sformatf("cnt%0d", i), 32'(scs[i]), 32'(scnt[i]));
                if ((fr | lus) && scnt[i] < cmax[i]) scnt[i] = scnt[i] + 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic red, input logic req);
        rs1D = r1; rs2D = r2; use_rs1D = u1; use_rs2D = u2;
        rdE = rd; mem_readE = mr; redirectE = red; mem_reqM = req;
    endtask

    int sb0;

    initial begin
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        NRST = 1'b0;
        tick(); tick(); #2;
        chk("pin_rst_ctl", 32'(outs[0]), 32'd0);
        chk("pin_rst_state", 32'(sts[0]), 32'd0);
        tick(); NRST = 1'b1;

        // load-use in RUN: one bubble, LDUSE, back to RUN
        tick(); set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); #2;
        chk("pin_lu_ctl", 32'(outs[0]), 32'b1101000);
        chk("pin_lu_state", 32'(sts[0]), 32'd0);
        tick(); #2;
        chk("pin_ldu_state", 32'(sts[0]), 32'd1);
        chk("pin_ldu_ctl", 32'(outs[0]), 32'd0);
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("pin_back_run", 32'(sts[0]), 32'd0);

        // no hazard: rdE = x0, or source not used
        tick(); set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); #2;
        chk("pin_rd0", 32'(outs[0]), 32'd0);
        tick(); set_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); #2;
        chk("pin_nouse", 32'(outs[0]), 32'd0);

        // redirect wins over load-use
        tick(); set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); #2;
        chk("pin_redir_ctl", 32'(outs[0]), 32'b0011000);
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("pin_redir_state", 32'(sts[0]), 32'd0);

        // MEM_LAT=4 access, mem_reqM held 4 cycles
        sb0 = int'(if_b.stall_cycles);
        for (int k = 0; k < 4; k++) begin
            tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #2;
            chk($sformatf("pin_mem_ctl%0d", k), 32'(outs[1]), (k < 3) ? 32'b1100110 : 32'b0000001);
        end
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("pin_mem_delta", 32'(int'(if_b.stall_cycles) - sb0), 32'd3);

        // final MWAIT cycle coincident with a redirect
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #2;
        chk("pin_mw_redir_ctl", 32'(outs[1]), 32'b0011001);
        chk("pin_mw_redir_st", 32'(sts[1]), 32'd2);
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("pin_mw_redir_next", 32'(sts[1]), 32'd0);

        // reset asserted while MWAIT holds cnt=2
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("pin_pre_rst_st", 32'(sts[1]), 32'd2);
        NRST = 1'b0; #1;
        chk("pin_mid_rst_ctl", 32'(outs[1]), 32'd0);
        chk("pin_mid_rst_st", 32'(sts[1]), 32'd0);
        chk("pin_mid_rst_cnt", 32'(scs[1]), 32'd0);
        tick(); NRST = 1'b1;

        // MEM_LAT=1: ack and load-use bubble in the same cycle
        tick(); set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1); #2;
        chk("pin_lat1_ctl", 32'(outs[2]), 32'b1101001);

        // continuous load-use + memory traffic: 4-bit counter saturates
        for (int k = 0; k < 24; k++) tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); #2;
        chk("pin_sat", 32'(scs[1]), 32'd15);
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        #2;
        chk("pin_sat_hold", 32'(scs[1]), 32'd15);

        // mixed traffic over a small register set
        for (int k = 0; k < 60; k++) begin
            tick();
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
        end
        tick(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
